// File: rtl/counter_bank_pkg.sv
// Shared definitions for counter_bank: priority-select encodings and the
// per-channel next-value function used by every counter_bank_ch instance.
package counter_bank_pkg;

  typedef logic [2:0] sel_t;

  localparam sel_t SEL_CLEAR = 3'd0;
  localparam sel_t SEL_UP    = 3'd1;
  localparam sel_t SEL_DOWN  = 3'd2;
  localparam sel_t SEL_AUTO  = 3'd3;
  localparam sel_t SEL_HOLD  = 3'd4;

  // Values are carried at the 32-bit maximum width; callers keep the low WIDTH bits.
  typedef struct packed {
    logic [31:0] value;
    logic        term;
    logic        update;
  } next_t;

  function automatic next_t next_value(input logic [31:0] count,
                                       input sel_t        sel,
                                       input logic        saturate,
                                       input int unsigned width);
    logic [31:0] all_ones;
    next_t       n;
    all_ones = 32'((64'd1 << width) - 64'd1);
    n.value  = count;
    n.term   = 1'b0;
    n.update = 1'b1;
    case (sel)
      SEL_CLEAR: n.value = '0;
      SEL_UP, SEL_AUTO: begin
        if (count == all_ones) begin
          n.term  = 1'b1;
          n.value = saturate ? all_ones : '0;
        end else begin
          n.value = count + 32'd1;
        end
      end
      SEL_DOWN: begin
        if (count == '0) begin
          n.term  = 1'b1;
          n.value = saturate ? '0 : all_ones;
        end else begin
          n.value = count - 32'd1;
        end
      end
      default: n.update = 1'b0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/counter_bank_ch.sv
// One counter channel: priority select, wrap/saturate update, registered
// count plus single-cycle match and terminal-count pulses.
module counter_bank_ch
  import counter_bank_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             enable,
  input  logic             saturate,
  input  logic             clear,
  input  logic             up,
  input  logic             down,
  input  logic [WIDTH-1:0] cmp,
  output logic [WIDTH-1:0] count,
  output logic             match,
  output logic             term
);

  sel_t  sel;
  next_t nxt;
  logic  unused_hi;

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    sel = SEL_HOLD;
    if (clear)               sel = SEL_CLEAR;
    else if (up)             sel = SEL_UP;
    else if (down)           sel = SEL_DOWN;
    else if (enable && tick) sel = SEL_AUTO;
  end

  assign nxt       = next_value(32'(count), sel, saturate, WIDTH);
  assign unused_hi = ^nxt.value;

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      count <= '0;
      match <= 1'b0;
      term  <= 1'b0;
    end else begin
      count <= nxt.value[WIDTH-1:0];
      term  <= nxt.term;
      // A hold never fires match; a saturating clamp counts as an update.
      match <= nxt.update && (nxt.value[WIDTH-1:0] == cmp);
    end
  end

endmodule

// File: rtl/counter_bank.sv
// NUM_CH independent counters sharing one programmable prescaler on sys_clk.
// Define COUNTER_BANK_CAPTURE_EN to add a coherent snapshot of all counts.
module counter_bank
  import counter_bank_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int WIDTH     = 8,
  parameter int DIV_WIDTH = 24
) (
  input  logic                    sys_clk,
  input  logic                    reset,
  input  logic [DIV_WIDTH-1:0]    div_reload,
  input  logic [NUM_CH-1:0]       enable,
  input  logic [NUM_CH-1:0]       saturate,
  input  logic [NUM_CH-1:0]       clear,
  input  logic [NUM_CH-1:0]       up,
  input  logic [NUM_CH-1:0]       down,
  input  logic [NUM_CH*WIDTH-1:0] cmp,
  output logic [NUM_CH*WIDTH-1:0] count,
  output logic [NUM_CH-1:0]       match,
  output logic [NUM_CH-1:0]       term,
  output logic                    tick
`ifdef COUNTER_BANK_CAPTURE_EN
  ,
  input  logic                    capture,
  output logic [NUM_CH*WIDTH-1:0] capture_count
`endif
);

  logic [DIV_WIDTH-1:0] div;

  // div_reload is only sampled at reload, so a new period starts after the current one ends.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      div  <= div_reload;
      tick <= 1'b0;
    end else if (div == '0) begin
      div  <= div_reload;
      tick <= 1'b1;
    end else begin
      div  <= div - DIV_WIDTH'(1);
      tick <= 1'b0;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    counter_bank_ch #(
      .WIDTH(WIDTH)
    ) u_ch (
      .sys_clk  (sys_clk),
      .reset    (reset),
      .tick     (tick),
      .enable   (enable[i]),
      .saturate (saturate[i]),
      .clear    (clear[i]),
      .up       (up[i]),
      .down     (down[i]),
      .cmp      (cmp[i*WIDTH +: WIDTH]),
      .count    (count[i*WIDTH +: WIDTH]),
      .match    (match[i]),
      .term     (term[i])
    );
  end

`ifdef COUNTER_BANK_CAPTURE_EN
  // Snapshot takes the pre-update counts so every channel comes from the same cycle.
  always_ff @(posedge sys_clk) begin
    if (reset)        capture_count <= '0;
    else if (capture) capture_count <= count;
  end
`endif

endmodule
